// File: rtl/mul_step3_round_pkg.sv
// Shared constants, types and helpers for the final FP multiply stage
// (normalize, round, pack to binary32).
package mul_step3_round_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned EINT_W = EXP_W + 2;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned FRM_W  = 3;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [FRM_W-1:0] {
        FRM_RNE = 3'b000,
        FRM_RTZ = 3'b001,
        FRM_RDN = 3'b010,
        FRM_RUP = 3'b011,
        FRM_RMM = 3'b100
    } frm_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Operand set handed from the exponent-add stage to the rounder
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic              ovf;
        logic              unf;
        logic              zero;
        logic [PROD_W-1:0] product;
        logic [FRM_W-1:0]  frm;
    } rnd_in_t;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MAXFIN = EXP_W'(2 * BIAS);

    localparam fp32_t FP_QNAN   = '{sign: 1'b0, expo: EXP_MAX,    frac: {1'b1, {(MAN_W-1){1'b0}}}};
    localparam fp32_t FP_INF    = '{sign: 1'b0, expo: EXP_MAX,    frac: '0};
    localparam fp32_t FP_MAXFIN = '{sign: 1'b0, expo: EXP_MAXFIN, frac: '1};

    function automatic fp32_t fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                      input logic [MAN_W-1:0] f);
        fp32_t r;
        r.sign = s;
        r.expo = e;
        r.frac = f;
        return r;
    endfunction

    function automatic fp32_t fp_signed(input fp32_t base, input logic s);
        fp32_t r;
        r      = base;
        r.sign = s;
        return r;
    endfunction

    // NV and DZ can never be raised by a multiply rounding step
    function automatic logic [FLAG_W-1:0] mk_flags(input logic of, input logic uf,
                                                   input logic nx);
        logic [FLAG_W-1:0] f;
        f          = '0;
        f[FLAG_NV] = 1'b0;
        f[FLAG_DZ] = 1'b0;
        f[FLAG_OF] = of;
        f[FLAG_UF] = uf;
        f[FLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/mul_step3_round_if.sv
// Handshake and payload bundle between the exponent stage, this rounding
// stage and FPU writeback.
interface mul_step3_round_if;
    import mul_step3_round_pkg::*;

    logic              valid_in;
    logic              ready_out;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic              ovf_in;
    logic              unf_in;
    logic              zero_in;
    logic [PROD_W-1:0] product_in;
    logic [FRM_W-1:0]  frm;
    logic              valid_out;
    logic              ready_in;
    logic [FP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;

    modport master (
        output valid_in, sign_in, exp_in, ovf_in, unf_in, zero_in, product_in, frm,
        output ready_in,
        input  ready_out, valid_out, result, flags
    );

    modport slave (
        input  valid_in, sign_in, exp_in, ovf_in, unf_in, zero_in, product_in, frm,
        input  ready_in,
        output ready_out, valid_out, result, flags
    );

endinterface

// File: rtl/mul_round_unit.sv
// Combinational normalize, round and special-case packing of a 48-bit
// significand product into a binary32 result with exception flags.
module mul_round_unit
    import mul_step3_round_pkg::*;
(
    input  rnd_in_t            op_i,
    output fp32_t              res_c_o,
    output logic [FLAG_W-1:0]  flags_c_o
);

    localparam logic signed [EINT_W-1:0] E_MIN_NORM = EINT_W'(1);
    localparam logic signed [EINT_W-1:0] E_OVF      = EINT_W'(EXP_MAX);

    logic [MAN_W-1:0]         man;
    logic                     guard;
    logic                     sticky;
    logic                     inexact;
    logic                     inc;
    logic                     to_inf;
    logic [MAN_W:0]           man_rnd;
    logic signed [EINT_W-1:0] e_norm;
    logic signed [EINT_W-1:0] e_fin;

    // Product of two [1,2) significands lies in [1,4): at most one right shift
    always_comb begin
        if (op_i.product[PROD_W-1]) begin
            man    = op_i.product[PROD_W-2 -: MAN_W];
            guard  = op_i.product[PROD_W-2-MAN_W];
            sticky = |op_i.product[PROD_W-3-MAN_W:0];
            e_norm = EINT_W'(op_i.expo) + EINT_W'(1);
        end else begin
            man    = op_i.product[PROD_W-3 -: MAN_W];
            guard  = op_i.product[PROD_W-3-MAN_W];
            sticky = |op_i.product[PROD_W-4-MAN_W:0];
            e_norm = EINT_W'(op_i.expo);
        end
    end

    // Round increment and overflow saturation direction; unknown modes act as RNE
    always_comb begin
        inexact = guard | sticky;
        inc     = guard & (sticky | man[0]);
        to_inf  = 1'b1;
        case (op_i.frm)
            FRM_RTZ: begin
                inc    = 1'b0;
                to_inf = 1'b0;
            end
            FRM_RDN: begin
                inc    = op_i.sign & inexact;
                to_inf = op_i.sign;
            end
            FRM_RUP: begin
                inc    = ~op_i.sign & inexact;
                to_inf = ~op_i.sign;
            end
            FRM_RMM: inc = guard;
            default: ;
        endcase
        man_rnd = {1'b0, man} + (MAN_W+1)'(inc);
        e_fin   = e_norm + EINT_W'(man_rnd[MAN_W]);
    end

    // A rounding carry leaves the fraction field all-zero, so man_rnd is used as is
    always_comb begin
        res_c_o   = fp_pack(op_i.sign, e_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]);
        flags_c_o = mk_flags(1'b0, 1'b0, inexact);
        if (op_i.zero) begin
            res_c_o   = fp_pack(op_i.sign, '0, '0);
            flags_c_o = '0;
        end else if (op_i.unf || (e_fin < E_MIN_NORM)) begin
            res_c_o   = fp_pack(op_i.sign, '0, '0);
            flags_c_o = mk_flags(1'b0, 1'b1, 1'b1);
        end else if (op_i.ovf || (e_fin >= E_OVF)) begin
            res_c_o   = to_inf ? fp_signed(FP_INF, op_i.sign)
                               : fp_signed(FP_MAXFIN, op_i.sign);
            flags_c_o = mk_flags(1'b1, 1'b0, 1'b1);
        end
    end

endmodule

// File: rtl/mul_step3_round.sv
// Final FP multiply stage: rounds the incoming product and holds the packed
// result in a one-deep output register with a valid/ready handshake.
module mul_step3_round
    import mul_step3_round_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    mul_step3_round_if.slave rnd_if
);

    rnd_in_t           op;
    fp32_t             res_c;
    logic [FLAG_W-1:0] flags_c;
    logic              ready_c;
    logic              take_c;
    logic              drain_c;

    logic              valid_q;
    logic              valid_d;
    fp32_t             result_q;
    fp32_t             result_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    always_comb begin
        op         = '0;
        op.sign    = rnd_if.sign_in;
        op.expo    = rnd_if.exp_in;
        op.ovf     = rnd_if.ovf_in;
        op.unf     = rnd_if.unf_in;
        op.zero    = rnd_if.zero_in;
        op.product = rnd_if.product_in;
        op.frm     = rnd_if.frm;
    end

    mul_round_unit u_round (
        .op_i      (op),
        .res_c_o   (res_c),
        .flags_c_o (flags_c)
    );

    // Accepting while draining keeps the stage at full throughput
    assign ready_c = rnd_if.ready_in | ~valid_q;
    assign take_c  = rnd_if.valid_in & ready_c;
    assign drain_c = valid_q & rnd_if.ready_in;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (take_c) begin
            valid_d  = 1'b1;
            result_d = res_c;
            flags_d  = flags_c;
        end else if (drain_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign rnd_if.ready_out = ready_c;
    assign rnd_if.valid_out = valid_q;
    assign rnd_if.result    = result_q;
    assign rnd_if.flags     = flags_q;

endmodule
